// File: rtl/morse_keyer_pkg.sv
// rtl/morse_keyer_pkg.sv - shared FSM states and symbol codes for the morse keyer
package morse_keyer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_PRESS_DEB   = 3'd1,
    ST_HELD        = 3'd2,
    ST_RELEASE_DEB = 3'd3,
    ST_GAP_WAIT    = 3'd4
  } state_e;

  localparam logic [1:0] MORSE_DOT   = 2'b01;
  localparam logic [1:0] MORSE_LINE  = 2'b11;
  localparam int         MAX_SYMBOLS = 5;

endpackage

// File: rtl/input_sync.sv
// rtl/input_sync.sv - two-flop synchronizer for the raw key level
module input_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the asynchronous level through two flops before anything decides on it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/morse_keyer.sv
// rtl/morse_keyer.sv - debounced single-key morse keyer classifying dots, lines, gaps and aborts
module morse_keyer
  import morse_keyer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DOT_MAX_CYCLES  = 12500000,
  parameter int ABORT_CYCLES    = 50000000,
  parameter int GAP_CYCLES      = 25000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       user_input,
  input  logic       clear,
  output logic       ld_dot,
  output logic       ld_line,
  output logic       ld_gap,
  output logic       ld_abort,
  output logic [2:0] sym_count,
  output logic       full
);

  localparam int CNT_MAX = (ABORT_CYCLES > GAP_CYCLES) ? ABORT_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] DOT_MAX  = CW'(DOT_MAX_CYCLES);
  localparam logic [CW-1:0] ABORT_AT = CW'(ABORT_CYCLES);
  localparam logic [2:0]    SYM_FULL = 3'(MAX_SYMBOLS);

  logic          key_s;
  state_e        state_q;
  logic [CW-1:0] deb_q;
  logic [CW-1:0] dur_q;
  logic [CW-1:0] gap_q;
  logic [2:0]    sym_q;
  logic          dot_q;
  logic          line_q;
  logic          gap_pulse_q;
  logic          abort_q;

  logic [CW-1:0] dur_d;
  logic [1:0]    sym_code_d;
  logic          reject_d;

  input_sync u_input_sync (
    .clk_i  (clock),
    .rst_ni (resetn),
    .d_i    (user_input),
    .q_o    (key_s)
  );

  // Saturating press length and the symbol the current press would become
  always_comb begin
    dur_d      = (dur_q >= ABORT_AT) ? dur_q : dur_q + 1'b1;
    sym_code_d = (dur_q < DOT_MAX) ? MORSE_DOT : MORSE_LINE;
    reject_d   = (dur_q >= ABORT_AT) || (sym_q == SYM_FULL);
  end

  // Key FSM: debounce press and release, time the press, classify, then time the gap
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      deb_q       <= '0;
      dur_q       <= '0;
      gap_q       <= '0;
      sym_q       <= '0;
      dot_q       <= 1'b0;
      line_q      <= 1'b0;
      gap_pulse_q <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      dot_q       <= 1'b0;
      line_q      <= 1'b0;
      gap_pulse_q <= 1'b0;
      abort_q     <= 1'b0;
      if (clear) begin
        state_q <= ST_IDLE;
        deb_q   <= '0;
        dur_q   <= '0;
        gap_q   <= '0;
        sym_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (key_s) begin
              state_q <= ST_PRESS_DEB;
              deb_q   <= '0;
            end
          end
          ST_PRESS_DEB: begin
            if (!key_s) begin
              state_q <= (sym_q != 3'd0) ? ST_GAP_WAIT : ST_IDLE;
              gap_q   <= '0;
            end else if (deb_q == DEB_LAST) begin
              state_q <= ST_HELD;
              dur_q   <= '0;
            end else begin
              deb_q <= deb_q + 1'b1;
            end
          end
          ST_HELD: begin
            dur_q <= dur_d;
            if (!key_s) begin
              state_q <= ST_RELEASE_DEB;
              deb_q   <= '0;
            end
          end
          ST_RELEASE_DEB: begin
            dur_q <= dur_d;
            if (key_s) begin
              // a short bounce low is folded into the same press
              state_q <= ST_HELD;
            end else if (deb_q == DEB_LAST) begin
              state_q <= ST_GAP_WAIT;
              gap_q   <= '0;
              if (reject_d) begin
                abort_q <= 1'b1;
              end else begin
                dot_q  <= (sym_code_d == MORSE_DOT);
                line_q <= (sym_code_d == MORSE_LINE);
                sym_q  <= sym_q + 3'd1;
              end
            end else begin
              deb_q <= deb_q + 1'b1;
            end
          end
          ST_GAP_WAIT: begin
            if (key_s) begin
              state_q <= ST_PRESS_DEB;
              deb_q   <= '0;
            end else if (gap_q == GAP_LAST) begin
              state_q     <= ST_IDLE;
              gap_pulse_q <= 1'b1;
              sym_q       <= '0;
            end else begin
              gap_q <= gap_q + 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign ld_dot    = dot_q;
  assign ld_line   = line_q;
  assign ld_gap    = gap_pulse_q;
  assign ld_abort  = abort_q;
  assign sym_count = sym_q;
  assign full      = (sym_q == SYM_FULL);

endmodule

// File: doc/morse_keyer.md
MORSE_KEYER -- requirements
Module: morse_keyer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles needed to accept a level change.
REQ-002 SHALL have parameter DOT_MAX_CYCLES, default 12500000: a held duration below this is a dot.
REQ-003 SHALL have parameter ABORT_CYCLES, default 50000000: a held duration at or above this is an abort.
REQ-004 SHALL have parameter GAP_CYCLES, default 25000000: idle cycles after a release that end a character.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port user_input, input, 1 bit: raw key, active-high, asynchronous to clock.
REQ-008 SHALL have port clear, input, 1 bit: synchronous abandon of the current character.
REQ-009 SHALL have port ld_dot, output, 1 bit: one-cycle pulse when a dot is accepted.
REQ-010 SHALL have port ld_line, output, 1 bit: one-cycle pulse when a line is accepted.
REQ-011 SHALL have port ld_gap, output, 1 bit: one-cycle pulse at end of character.
REQ-012 SHALL have port ld_abort, output, 1 bit: one-cycle pulse when a symbol is rejected.
REQ-013 SHALL have port sym_count, output, 3 bits: symbols accepted in the current character, range 0..5.
REQ-014 SHALL have port full, output, 1 bit: high when sym_count equals 5.

Function
REQ-015 SHALL pass user_input through a 2-flop synchronizer; all decisions use the synchronized level (2-cycle latency).
REQ-016 SHALL implement FSM states IDLE, PRESS_DEB, HELD, RELEASE_DEB and GAP_WAIT.
REQ-017 IDLE: synchronized high -> PRESS_DEB with debounce counter at 0.
REQ-018 PRESS_DEB: high for DEBOUNCE_CYCLES consecutive cycles -> HELD with duration counter at 0; low earlier -> GAP_WAIT if sym_count>0, else IDLE.
REQ-019 HELD: duration counter increments each cycle, saturating at ABORT_CYCLES; low -> RELEASE_DEB.
REQ-020 RELEASE_DEB: duration keeps counting; high before DEBOUNCE_CYCLES low cycles -> HELD, bounce treated as part of one press.
REQ-021 RELEASE_DEB: low for DEBOUNCE_CYCLES -> classify on the next edge, then go to GAP_WAIT with gap counter at 0.
REQ-022 Classification: duration < DOT_MAX_CYCLES -> ld_dot; DOT_MAX_CYCLES <= duration < ABORT_CYCLES -> ld_line; duration >= ABORT_CYCLES -> ld_abort.
REQ-023 ld_dot or ld_line SHALL increment sym_count in the same edge; ld_abort SHALL leave sym_count unchanged.
REQ-024 When full, a classified dot or line SHALL instead pulse ld_abort; sym_count stays 5.
REQ-025 GAP_WAIT: GAP_CYCLES consecutive low cycles -> pulse ld_gap, set sym_count to 0, go to IDLE; synchronized high -> PRESS_DEB.
REQ-026 At most one of ld_dot, ld_line, ld_gap, ld_abort SHALL be high in any cycle; each is exactly one cycle wide.
REQ-027 clear SHALL take priority over all other events: next state IDLE, all counters and sym_count 0, no pulses in that cycle; a key still held goes through PRESS_DEB again.
REQ-028 All counters SHALL be sized to hold max(ABORT_CYCLES, GAP_CYCLES) and SHALL never wrap.

Reset
REQ-029 resetn low SHALL asynchronously force state IDLE, synchronizer flops to 0, all counters to 0, all outputs to 0.
REQ-030 Reset asserted mid-press SHALL produce no pulse; after release, a key still held SHALL be treated as a new press.

Structure
REQ-031 A shared package SHALL hold the FSM state encodings, the symbol codes MORSE_DOT=2'b01 and MORSE_LINE=2'b11, and MAX_SYMBOLS=5.
REQ-032 SHALL contain one sub-module, input_sync (2-flop synchronizer with async active-low reset); all other logic stays in morse_keyer.

Verification (DEBOUNCE_CYCLES=4, DOT_MAX_CYCLES=20, ABORT_CYCLES=60, GAP_CYCLES=30)
REQ-033 Clean 10-cycle press then release -> one ld_dot; sym_count=1; ld_gap 30 idle cycles later; sym_count=0.
REQ-034 35-cycle press -> one ld_line; 70-cycle press -> ld_abort only, sym_count unchanged.
REQ-035 Press with 2-cycle glitch low mid-hold, total 30 cycles -> single ld_line, no extra pulse.
REQ-036 Six 10-cycle presses with 10-cycle gaps -> five ld_dot, then ld_abort; full=1; sym_count=5.
REQ-037 clear or resetn asserted during HELD -> no pulse, sym_count=0; a key still held re-enters PRESS_DEB.
